// File: rtl/cam_line_buffer.sv
// cam_line_buffer: packs an 8-bit DVP byte stream into RGB565 words and
// ping-pongs alternate lines between two FIFOs for the AXI read side.
`default_nettype none

module cam_line_buffer #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic                  i_pix_vld,
  input  logic [7:0]            i_pix_data,
  input  logic                  i_fifo_rd_en,
  input  logic                  i_fifo_choose,
  output logic [DATA_WIDTH-1:0] o_fifo1_rd_data,
  output logic [DATA_WIDTH-1:0] o_fifo2_rd_data,
  output logic [CNT_W-1:0]      o_fifo1_cnt,
  output logic [CNT_W-1:0]      o_fifo2_cnt,
  output logic                  o_line_done,
  output logic [15:0]           o_line_cnt,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_err_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_IDLE       = 2'd1,
    S_LINE       = 2'd2,
    S_EOL        = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                  href_d, vsync_d, pix_vld_d;
  logic [7:0]            pix_data_d;
  logic                  phase, line_sel;
  logic [7:0]            hi_byte;
  logic                  href_rise, href_fall, vsync_rise, vsync_fall;
  logic                  capture, abort, line_start;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            ovf_evt, udf_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d     <= 1'b0;
      vsync_d    <= 1'b0;
      pix_vld_d  <= 1'b0;
      pix_data_d <= 8'h00;
    end else begin
      href_d     <= i_href;
      vsync_d    <= i_vsync;
      pix_vld_d  <= i_pix_vld;
      pix_data_d <= i_pix_data;
    end
  end

  assign href_rise  = i_href & ~href_d;
  assign href_fall  = ~i_href & href_d;
  assign vsync_rise = i_vsync & ~vsync_d;
  assign vsync_fall = ~i_vsync & vsync_d;
  assign capture    = pix_vld_d & href_d & ~vsync_d;
  assign abort      = vsync_rise & (state != S_WAIT_FRAME);
  assign line_start = href_rise & ~i_vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT_FRAME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    wr_data   = {hi_byte, pix_data_d};
    unique case (state)
      S_WAIT_FRAME: if (vsync_fall) state_nxt = S_IDLE;
      S_IDLE:       if (line_start) state_nxt = S_LINE;
      S_LINE: begin
        // The last byte of a line is still in the pipeline on the href fall cycle.
        if (capture && phase) wr_req = 1'b1;
        if (href_fall) state_nxt = S_EOL;
      end
      S_EOL: begin
        if (phase) begin
          wr_req  = 1'b1;
          wr_data = {hi_byte, 8'h00};
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_WAIT_FRAME;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      wr_req    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= 1'b0;
      hi_byte     <= 8'h00;
      line_sel    <= 1'b0;
      o_line_cnt  <= 16'h0000;
      o_line_done <= 1'b0;
    end else begin
      o_line_done <= (state == S_EOL) && !abort;
      if (abort) begin
        phase      <= 1'b0;
        line_sel   <= 1'b0;
        o_line_cnt <= 16'h0000;
      end else begin
        unique case (state)
          S_IDLE: if (line_start) phase <= 1'b0;
          S_LINE: if (capture) begin
            if (!phase) hi_byte <= pix_data_d;
            phase <= ~phase;
          end
          S_EOL: begin
            phase    <= 1'b0;
            line_sel <= ~line_sel;
            if (o_line_cnt != 16'hFFFF) o_line_cnt <= o_line_cnt + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_me, pop_me, pop_ok, wr_ok;

    assign wr_me  = wr_req & (line_sel == 1'(g));
    assign pop_me = i_fifo_rd_en & (i_fifo_choose == 1'(g));
    assign pop_ok = pop_me & (cnt != '0);
    // Full FIFO still accepts when the same cycle frees a slot.
    assign wr_ok  = wr_me & ((cnt < CNT_W'(DEPTH)) | pop_ok);
    assign ovf_evt[g] = wr_me & ~wr_ok;
    assign udf_evt[g] = pop_me & (cnt == '0);

    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cnt     <= '0;
        rd_data <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok) begin
          rd_ptr  <= rd_ptr + AW'(1);
          rd_data <= mem[rd_ptr];
        end
        cnt <= cnt + CNT_W'(wr_ok) - CNT_W'(pop_ok);
      end
    end
  end

  assign o_fifo1_rd_data = g_fifo[0].rd_data;
  assign o_fifo2_rd_data = g_fifo[1].rd_data;
  assign o_fifo1_cnt     = g_fifo[0].cnt;
  assign o_fifo2_cnt     = g_fifo[1].cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (|ovf_evt)       o_overflow <= 1'b1;
      else if (i_err_clr) o_overflow <= 1'b0;
      if (|udf_evt)       o_underflow <= 1'b1;
      else if (i_err_clr) o_underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire
